mips_dmem_bridge: RTL
=====================

// Module: mips_dmem_bridge
// PURPOSE
//  Data-side bridge between the single-cycle core's data port (word addr, wdata, byte write mask)
//  and a variable-latency data memory with valid/ready request and valid response channels.
//  Posts stores into a small store buffer so they retire without stalling. Stalls the core on
//  load misses; the core gates its PC/register enables with ~core_stall.
//  One memory transaction outstanding at a time; writes are posted (no response).
// PARAMETERS
//  WB_DEPTH  4   store-buffer entries; power of 2, >= 2
//  ADDR_W    30  word-address width (byte addr [31:2])
//  DATA_W    32  data width; byte mask width = DATA_W/8
// PORTS
//  clk             in   1       clock; all state updates on rising edge
//  rst             in   1       reset: one clock, synchronous, active-high
//  core_addr       in   ADDR_W  core data word address
//  core_wdata      in   DATA_W  core store data
//  core_we         in   4       core byte write mask; != 0 means store
//  core_re         in   1       core load request
//  core_rdata      out  DATA_W  load data, valid in the cycle core_stall == 0 for a load
//  core_stall      out  1       hold core state this cycle
//  mem_req_valid   out  1       memory request valid
//  mem_req_ready   in   1       memory accepts request (handshake = valid & ready)
//  mem_req_addr    out  ADDR_W  request word address
//  mem_req_wdata   out  DATA_W  request write data
//  mem_req_we      out  4       request byte mask; 0 = read
//  mem_resp_valid  in   1       read data valid (exactly one per accepted read)
//  mem_resp_data   in   DATA_W  read data
// BEHAVIOUR
//  Reset: FIFO emptied (pending stores discarded), state IDLE, all outputs 0.
//  FSM states IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE:
//   IDLE: load miss -> RD_REQ; else FIFO non-empty -> DRAIN; else stay.
//   DRAIN: mem_req = FIFO head, valid=1; on handshake pop; to RD_REQ if a load miss
//     is pending, else to IDLE when FIFO is empty after the pop, else stay.
//   RD_REQ: mem_req_valid=1, addr=latched load addr, we=0; handshake -> RD_WAIT.
//   RD_WAIT: mem_resp_valid -> latch mem_resp_data, -> RD_DONE.
//   RD_DONE: core_stall=0, core_rdata=latched data; -> IDLE next cycle.
//  A load pending in DRAIN takes over after the in-flight write handshake; reads
//   have priority over draining.
//  Store (core_we != 0; core_re ignored): FIFO not full -> enqueue {addr,wdata,we}, stall=0.
//   FIFO full -> stall=1 and no enqueue. Full is evaluated on the registered count, so a
//   same-cycle pop does not unstall. Enqueue+pop in one cycle leaves count unchanged.
//  Load (core_re & core_we == 0): search FIFO for youngest entry with matching addr:
//   match with we == 4'hF -> forward its data, stall=0, no memory access (hit).
//   match with partial mask -> stall; drain until no match remains, then treat as a miss.
//   no match -> miss: stall=1 from the request cycle through RD_WAIT.
//  Miss latency = 3 + memory ready wait + response latency cycles:
//   cycle0 detect, cycle1 RD_REQ, RD_WAIT until resp, RD_DONE releases.
//  The core holds addr/re/we/wdata stable while core_stall=1.
//  mem_resp_valid outside RD_WAIT is ignored.
//  mem_req outputs hold stable while valid & ~ready, with no retraction.
//  core_rdata=0 when no load completes. Pointers wrap modulo WB_DEPTH; count is log2(WB_DEPTH)+1 bits.
// STRUCTURE
//  Package mips_mem_pkg holds:
//   - typedef enum dmem_state_e {IDLE,DRAIN,RD_REQ,RD_WAIT,RD_DONE}
//   - typedef struct wb_entry_t {addr,data,we}
//   - constant WB_MASK_FULL = 4'hF
//  Sub-module mips_store_buffer: circular FIFO with push/pop, full/empty, and a combinational
//   youngest-match lookup returning {hit, full_mask, data}. The FSM and the core-side mux
//   live in the top module.
// TESTING
//  1. Store A=0x10 D=0xCAFEBABE we=F, ready=1: no stall; next cycles mem_req we=F addr 0x10, FIFO empties.
//  2. 5 stores, ready=0, DEPTH=4: 4 accepted, 5th sees stall=1 until ready=1 pops one.
//  3. Store 0x20=0x12345678 we=F, then load 0x20 with ready=0: rdata=0x12345678, stall=0, no read req.
//  4. Store 0x30 we=4'h3, then load 0x30: stall; the write drains before the read. Read resp
//     0xAABB1122 after 2 cycles: core sees 0xAABB1122 in RD_DONE.
//  5. Load miss 0x40, ready=1, resp 3 cycles later: stall=1 for 5 cycles, then one cycle
//     with stall=0 and rdata=resp.
//  6. rst asserted during RD_WAIT with 2 stores queued: next cycle IDLE, all outputs 0, FIFO empty,
//     and a late mem_resp_valid is ignored.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types for the data-side memory bridge: FSM states, store-buffer entry
// layout and the full byte-mask constant.
package mips_mem_pkg;

  localparam int MEM_ADDR_W = 30;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = MEM_DATA_W / 8;

  localparam logic [MEM_MASK_W-1:0] WB_MASK_FULL = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    RD_REQ,
    RD_WAIT,
    RD_DONE
  } dmem_state_e;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
    logic [MEM_MASK_W-1:0] we;
  } wb_entry_t;

endpackage

// File: rtl/mips_store_buffer.sv
// Circular store buffer holding posted writes until the bridge drains them.
// Also provides a combinational lookup of the youngest entry matching an address
// so loads can be forwarded or held back behind a partial write.
module mips_store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  wb_entry_t                 push_entry,
  input  logic                      pop,
  output wb_entry_t                 head_entry,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  input  logic [MEM_ADDR_W-1:0]     lk_addr,
  output logic                      lk_hit,
  output logic                      lk_full_mask,
  output logic [MEM_DATA_W-1:0]     lk_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign head_entry = mem_q[rd_ptr_q];
  assign push_ok    = push && !full;
  assign pop_ok     = pop && !empty;

  // Next pointer/count/storage values from push and pop requests.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx          = '0;
    lk_hit       = 1'b0;
    lk_full_mask = 1'b0;
    lk_data      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (mem_q[idx].addr == lk_addr)) begin
        lk_hit       = 1'b1;
        lk_full_mask = (mem_q[idx].we == WB_MASK_FULL);
        lk_data      = mem_q[idx].data;
      end
    end
  end

  // Buffer state register; reset discards any pending stores.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/mips_dmem_bridge.sv
// Data-side bridge between the single-cycle core and a variable-latency memory.
// Stores are posted into a store buffer; loads hit the buffer when a full-word
// store to the same address is pending, otherwise they stall the core for a read.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no memory traffic; detect load misses, start draining stores
// DRAIN   | presenting store-buffer head to memory, pop on handshake
// RD_REQ  | presenting the latched load address as a read request
// RD_WAIT | read accepted, waiting for the memory response
// RD_DONE | one cycle releasing the core with the latched read data
module mips_dmem_bridge
  import mips_mem_pkg::*;
#(
  parameter int WB_DEPTH = 4,
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [DATA_W/8-1:0]   core_we,
  input  logic                  core_re,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_we,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_data
);

  localparam int CNT_W = $clog2(WB_DEPTH) + 1;

  dmem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  wb_entry_t         push_entry;
  wb_entry_t         head_entry;
  logic              wb_push;
  logic              wb_pop;
  logic              wb_full;
  logic              wb_empty;
  logic [CNT_W-1:0]  wb_count;
  logic              lk_hit;
  logic              lk_full_mask;
  logic [DATA_W-1:0] lk_data;

  logic core_active;
  logic is_store;
  logic is_load;
  logic fwd_hit;
  logic load_miss;

  // Core requests are only decoded while no read is in progress; during a
  // read the core is holding the same load and must not be re-evaluated.
  assign core_active = (state_q == IDLE) || (state_q == DRAIN);
  assign is_store    = |core_we;
  assign is_load     = core_re && !is_store;
  assign wb_push     = core_active && is_store && !wb_full;
  assign fwd_hit     = core_active && is_load && lk_hit && lk_full_mask;
  assign load_miss   = core_active && is_load && !lk_hit;
  assign push_entry  = '{addr: core_addr, data: core_wdata, we: core_we};

  mips_store_buffer #(
    .DEPTH(WB_DEPTH)
  ) u_wb (
    .clk         (clk),
    .rst         (rst),
    .push        (wb_push),
    .push_entry  (push_entry),
    .pop         (wb_pop),
    .head_entry  (head_entry),
    .full        (wb_full),
    .empty       (wb_empty),
    .count       (wb_count),
    .lk_addr     (core_addr),
    .lk_hit      (lk_hit),
    .lk_full_mask(lk_full_mask),
    .lk_data     (lk_data)
  );

  // Next-state, memory request and core-side outputs.
  always_comb begin
    state_d       = state_q;
    ld_addr_d     = ld_addr_q;
    rdata_d       = rdata_q;
    wb_pop        = 1'b0;
    core_stall    = 1'b0;
    core_rdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    mem_req_we    = '0;

    case (state_q)
      IDLE: begin
        if (load_miss) begin
          state_d   = RD_REQ;
          ld_addr_d = core_addr;
        end else if (!wb_empty) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = head_entry.addr;
        mem_req_wdata = head_entry.data;
        mem_req_we    = head_entry.we;
        // The write already on the bus must complete before a read takes over.
        if (mem_req_ready) begin
          wb_pop = 1'b1;
          if (load_miss) begin
            state_d   = RD_REQ;
            ld_addr_d = core_addr;
          end else if ((wb_count == CNT_W'(1)) && !wb_push) begin
            state_d = IDLE;
          end
        end
      end
      RD_REQ: begin
        core_stall    = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = ld_addr_q;
        if (mem_req_ready) begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        core_stall = 1'b1;
        if (mem_resp_valid) begin
          rdata_d = mem_resp_data;
          state_d = RD_DONE;
        end
      end
      RD_DONE: begin
        core_rdata = rdata_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Full is taken from the registered count, so a pop this cycle does not
    // release a stalled store until the next cycle.
    if (core_active) begin
      if (is_store) begin
        core_stall = wb_full;
      end else if (is_load) begin
        if (fwd_hit) begin
          core_rdata = lk_data;
        end else begin
          core_stall = 1'b1;
        end
      end
    end
  end

  // FSM and read-path registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ld_addr_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ld_addr_q <= ld_addr_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule
